audio_i2s_rx: RTL and testbench

I2S slave receiver: accepts externally driven bit clock, word clock and serial data, and delivers left/right PCM sample pairs with a one-cycle valid strobe in the `I_clock` domain. It sits at the audio input boundary and is the receive-side counterpart of the team's I2S transmitter, sharing its framing: MSB first, one-bit delay after the word-clock edge, word clock low = left. All I2S inputs are treated as asynchronous and oversampled by `I_clock`, which must run at least 4x the bit-clock rate.

---
 rtl/audio_i2s_pkg.sv | 22 ++
 rtl/audio_i2s_sync.sv | 44 ++++
 rtl/audio_i2s_rx.sv | 148 ++++++++++++++
 tb/tb_audio_i2s_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// Shared I2S framing definitions (channel encoding, FSM states, default sizes)
// used by both the I2S receiver and transmitter.
package audio_i2s_pkg;

    localparam int unsigned I2S_WIDTH    = 16;
    localparam int unsigned I2S_SLOT_MAX = 32;

    localparam logic I2S_CH_LEFT  = 1'b0;
    localparam logic I2S_CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    // Bits needed for a counter that saturates at slot_max.
    function automatic int unsigned i2s_cnt_width(input int unsigned slot_max);
        return $clog2(slot_max + 1);
    endfunction

endpackage

// File: rtl/audio_i2s_sync.sv
// N-flop synchronizer for an asynchronous level, with an optional
// rising-edge strobe derived from one extra flop on the synchronized value.
module audio_i2s_sync #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RISE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

    generate
        if (RISE_EN) begin : g_rise
            logic last;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last <= 1'b0;
                end else begin
                    last <= chain[STAGES-1];
                end
            end

            assign rise = chain[STAGES-1] & ~last;
        end else begin : g_no_rise
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/audio_i2s_rx.sv
// I2S slave receiver: oversamples bit clock, word clock and data, and emits
// left/right PCM pairs with a one-cycle valid strobe.
module audio_i2s_rx
    import audio_i2s_pkg::*;
#(
    parameter int unsigned WIDTH    = I2S_WIDTH,
    parameter int unsigned SLOT_MAX = I2S_SLOT_MAX
) (
    input  logic             I_clock,
    input  logic             I_reset,
    input  logic             I_sclk,
    input  logic             I_wclk,
    input  logic             I_data,
    output logic [WIDTH-1:0] O_left,
    output logic [WIDTH-1:0] O_right,
    output logic             O_valid,
    output logic             O_short
);

    localparam int unsigned      CNT_W   = i2s_cnt_width(SLOT_MAX);
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    logic sclk_rise;
    logic wclk_s;
    logic data_s;
    logic sclk_level_unused;
    logic wclk_rise_unused;
    logic data_rise_unused;

    audio_i2s_sync #(.STAGES(2), .RISE_EN(1'b1)) u_sync_sclk (
        .clk  (I_clock),
        .rst  (I_reset),
        .d    (I_sclk),
        .q    (sclk_level_unused),
        .rise (sclk_rise)
    );

    audio_i2s_sync #(.STAGES(2), .RISE_EN(1'b0)) u_sync_wclk (
        .clk  (I_clock),
        .rst  (I_reset),
        .d    (I_wclk),
        .q    (wclk_s),
        .rise (wclk_rise_unused)
    );

    audio_i2s_sync #(.STAGES(2), .RISE_EN(1'b0)) u_sync_data (
        .clk  (I_clock),
        .rst  (I_reset),
        .d    (I_data),
        .q    (data_s),
        .rise (data_rise_unused)
    );

    i2s_state_t       state_q, state_d;
    logic             wclk_prev_q, wclk_prev_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic [WIDTH-1:0] left_d, right_d;
    logic             valid_d, short_d;

    logic [WIDTH-1:0] shift_cap;
    logic [CNT_W-1:0] cnt_inc;
    logic             slot_short;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            state_q     <= HUNT;
            wclk_prev_q <= 1'b0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            O_left      <= '0;
            O_right     <= '0;
            O_valid     <= 1'b0;
            O_short     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wclk_prev_q <= wclk_prev_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            O_left      <= left_d;
            O_right     <= right_d;
            O_valid     <= valid_d;
            O_short     <= short_d;
        end
    end

    // Bits land left-justified at their final position, so a short slot
    // commits with its missing LSBs already zero.
    always_comb begin
        state_d     = state_q;
        wclk_prev_d = wclk_prev_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_d      = O_left;
        right_d     = O_right;
        valid_d     = 1'b0;
        short_d     = 1'b0;
        shift_cap   = shift_q;
        cnt_inc     = bitcnt_q;

        if ((bitcnt_q < CNT_W'(WIDTH)) && data_s) begin
            shift_cap = shift_q | (MSB_ONE >> bitcnt_q);
        end
        if (bitcnt_q != CNT_W'(SLOT_MAX)) begin
            cnt_inc = bitcnt_q + CNT_W'(1);
        end
        slot_short = (cnt_inc < CNT_W'(WIDTH));

        if (sclk_rise) begin
            wclk_prev_d = wclk_s;
            if (wclk_s != wclk_prev_q) begin
                // Boundary: this rise carries the old slot's last bit.
                shift_d  = '0;
                bitcnt_d = '0;
                case (state_q)
                    HUNT: begin
                        if (wclk_s == I2S_CH_LEFT) begin
                            state_d = LEFT;
                        end
                    end
                    LEFT: begin
                        left_hold_d = shift_cap;
                        short_d     = slot_short;
                        state_d     = RIGHT;
                    end
                    RIGHT: begin
                        left_d  = left_hold_q;
                        right_d = shift_cap;
                        valid_d = 1'b1;
                        short_d = slot_short;
                        state_d = LEFT;
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end else begin
                shift_d  = shift_cap;
                bitcnt_d = cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Scoreboard bench for audio_i2s_rx: slot-level reference model predicts
// committed pairs and short-slot strobes, a monitor checks them as they appear.
`timescale 1ns/1ps
module tb_audio_i2s_rx;
    import audio_i2s_pkg::*;

    localparam int unsigned W = 16;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         sclk = 1'b0;
    logic         wclk = 1'b0;
    logic         data = 1'b0;
    logic [W-1:0] o_left, o_right;
    logic         o_valid, o_short;

    audio_i2s_rx #(.WIDTH(W), .SLOT_MAX(32)) dut (
        .I_clock (clk),
        .I_reset (rst),
        .I_sclk  (sclk),
        .I_wclk  (wclk),
        .I_data  (data),
        .O_left  (o_left),
        .O_right (o_right),
        .O_valid (o_valid),
        .O_short (o_short)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [W-1:0] l; logic [W-1:0] r; int cyc; } pair_t;
    typedef struct { logic right; int cyc; } short_t;

    pair_t  pairq[$];
    short_t shortq[$];
    int     pairs_seen, shorts_seen, pairs_pushed, shorts_pushed;

    // Monitor: every strobe must match the oldest predicted event.
    always @(negedge clk) begin
        pair_t  p;
        short_t s;
        if (!rst) begin
            if (o_valid) begin
                pairs_seen++;
                if (pairq.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else begin
                    p = pairq.pop_front();
                    check("pair_left", 32'(o_left), 32'(p.l));
                    check("pair_right", 32'(o_right), 32'(p.r));
                    check("valid_cycle", 32'(cyc), 32'(p.cyc));
                end
            end
            if (o_short) begin
                shorts_seen++;
                if (shortq.size() == 0) check("unexpected_short", 32'd1, 32'd0);
                else begin
                    s = shortq.pop_front();
                    check("short_with_valid", 32'(o_valid), 32'(s.right));
                    check("short_cycle", 32'(cyc), 32'(s.cyc));
                end
            end
        end
    end

    // Slot description: level, bit count, value right-justified in n bits.
    int          s_lvl[$];
    int          s_n[$];
    logic [31:0] s_word[$];

    // Per-bit-clock stimulus and the events expected at its rising edge.
    logic         e_w[$], e_d[$];
    bit           e_pair[$], e_short[$], e_sr[$];
    logic [W-1:0] e_l[$], e_r[$];

    task automatic clear_slots();
        s_lvl.delete(); s_n.delete(); s_word.delete();
    endtask

    task automatic add_slot(input int lvl, input int n, input logic [31:0] word);
        logic [31:0] mask;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        s_lvl.push_back(lvl);
        s_n.push_back(n);
        s_word.push_back(word & mask);
    endtask

    function automatic logic [W-1:0] justify(input logic [31:0] word, input int n);
        if (n >= int'(W)) return W'(word >> (n - int'(W)));
        return W'(word << (int'(W) - n));
    endfunction

    function automatic logic bit_of(input int s, input int i);
        logic [31:0] w;
        w = s_word[s];
        return w[s_n[s] - 1 - i];
    endfunction

    task automatic push_elem(input logic w, input logic d, input bit ep, input logic [W-1:0] l,
                             input logic [W-1:0] r, input bit es, input bit esr);
        e_w.push_back(w); e_d.push_back(d); e_pair.push_back(ep);
        e_l.push_back(l); e_r.push_back(r); e_short.push_back(es); e_sr.push_back(esr);
    endtask

    // Expected behaviour: the first left slot entered through a word-clock
    // edge after reset starts capture; each (left, right) pair after it is
    // delivered when the right slot closes; every closed slot from that left
    // slot on that carried fewer than W bits flags short.
    task automatic build();
        int   n_slots, f, len, c;
        logic lvl, d, trail;
        bit   ep, es, esr;
        logic [W-1:0] l, r;
        n_slots = s_lvl.size();
        f = -1;
        e_w.delete(); e_d.delete(); e_pair.delete(); e_l.delete();
        e_r.delete(); e_short.delete(); e_sr.delete();
        for (int s = 1; s < n_slots; s++) if (f < 0 && s_lvl[s] == 0) f = s;
        trail = ~1'(s_lvl[n_slots-1]);
        for (int s = 0; s <= n_slots; s++) begin
            len = (s < n_slots) ? s_n[s] : 1;
            lvl = (s < n_slots) ? 1'(s_lvl[s]) : trail;
            for (int j = 0; j < len; j++) begin
                ep = 0; es = 0; esr = 0; l = '0; r = '0;
                if (j == 0) d = (s == 0) ? 1'($urandom) : bit_of(s - 1, s_n[s-1] - 1);
                else        d = bit_of(s, j - 1);
                if (j == 0 && s >= 1 && f >= 0 && s - 1 >= f) begin
                    c = s - 1;
                    if (s_n[c] < int'(W)) begin
                        es  = 1;
                        esr = (s_lvl[c] == 1);
                    end
                    if (s_lvl[c] == 1 && c - 1 >= f) begin
                        ep = 1;
                        l  = justify(s_word[c-1], s_n[c-1]);
                        r  = justify(s_word[c], s_n[c]);
                    end
                end
                push_elem(lvl, d, ep, l, r, es, esr);
            end
        end
        for (int k = 0; k < 3; k++) push_elem(trail, 1'($urandom), 0, '0, '0, 0, 0);
    endtask

    task automatic drive(input int lo, input int hi, input int limit);
        pair_t  p;
        short_t s;
        for (int e = 0; e < e_w.size() && e < limit; e++) begin
            sclk = 1'b0; wclk = e_w[e]; data = e_d[e];
            repeat (lo) @(negedge clk);
            sclk = 1'b1;
            if (e_pair[e]) begin
                p.l = e_l[e]; p.r = e_r[e]; p.cyc = cyc + 3;
                pairq.push_back(p);
                pairs_pushed++;
            end
            if (e_short[e]) begin
                s.right = e_sr[e]; s.cyc = cyc + 3;
                shortq.push_back(s);
                shorts_pushed++;
            end
            repeat (hi) @(negedge clk);
        end
    endtask

    // Reset is asserted with the I2S inputs left where they were.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({name, "_rst_left"}, 32'(o_left), 32'd0);
        check({name, "_rst_right"}, 32'(o_right), 32'd0);
        check({name, "_rst_valid"}, 32'(o_valid), 32'd0);
        check({name, "_rst_short"}, 32'(o_short), 32'd0);
        sclk = 1'b0; wclk = 1'b0; data = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pairq.delete(); shortq.delete();
        pairs_seen = 0; shorts_seen = 0; pairs_pushed = 0; shorts_pushed = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string name, input int lo, input int hi, input int limit);
        do_reset(name);
        build();
        drive(lo, hi, limit);
        repeat (12) @(negedge clk);
        check({name, "_pending_pairs"}, 32'(pairq.size()), 32'd0);
        check({name, "_pending_shorts"}, 32'(shortq.size()), 32'd0);
        check({name, "_pair_count"}, 32'(pairs_seen), 32'(pairs_pushed));
        check({name, "_short_count"}, 32'(shorts_seen), 32'(shorts_pushed));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int nsl, lvl, lo, hi;

        // Nominal 16-bit frame.
        clear_slots();
        add_slot(1, 16, $urandom);
        add_slot(0, 16, 32'hA5C3);
        add_slot(1, 16, 32'h1234);
        run("nominal", 4, 4, 1 << 20);
        check("nominal_pairs", 32'(pairs_seen), 32'd1);
        check("nominal_left", 32'(o_left), 32'hA5C3);
        check("nominal_right", 32'(o_right), 32'h1234);

        // Reset mid-run, inputs held static afterwards.
        do_reset("idle");
        repeat (40) @(negedge clk);
        check("idle_left", 32'(o_left), 32'd0);
        check("idle_right", 32'(o_right), 32'd0);
        check("idle_valid_count", 32'(pairs_seen), 32'd0);
        check("idle_state", 32'(dut.state_q), 32'(HUNT));

        // Lock-in from the middle of a right slot.
        clear_slots();
        add_slot(1, 7, $urandom);
        for (int k = 0; k < 4; k++) add_slot(k % 2, 16, $urandom);
        run("lockin", 3, 3, 1 << 20);
        check("lockin_pairs", 32'(pairs_seen), 32'd2);

        // 32-bit slots truncate to the top 16 bits.
        clear_slots();
        add_slot(1, 32, $urandom);
        add_slot(0, 32, 32'hDEADBEEF);
        add_slot(1, 32, 32'h0000FFFF);
        run("long", 2, 3, 1 << 20);
        check("long_left", 32'(o_left), 32'hDEAD);
        check("long_right", 32'(o_right), 32'h0000);
        check("long_shorts", 32'(shorts_seen), 32'd0);

        // 12-bit slots are zero-padded and flagged short.
        clear_slots();
        add_slot(1, 12, $urandom);
        add_slot(0, 12, 32'hABC);
        add_slot(1, 12, $urandom);
        run("short", 4, 4, 1 << 20);
        check("short_left", 32'(o_left), 32'hABC0);
        check("short_shorts", 32'(shorts_seen), 32'd2);

        // Reset after 8 bits of left, then a clean frame.
        clear_slots();
        add_slot(1, 16, $urandom);
        add_slot(0, 16, $urandom);
        add_slot(1, 16, $urandom);
        run("partial", 4, 4, 25);
        check("partial_pairs", 32'(pairs_seen), 32'd0);
        clear_slots();
        add_slot(1, 16, $urandom);
        add_slot(0, 16, $urandom);
        add_slot(1, 16, $urandom);
        run("after_reset", 4, 4, 1 << 20);
        check("after_reset_pairs", 32'(pairs_seen), 32'd1);

        // Randomized slot lengths, phases and contents.
        for (int t = 0; t < 6; t++) begin
            clear_slots();
            nsl = 5 + int'($urandom_range(4));
            lvl = int'($urandom_range(1));
            for (int k = 0; k < nsl; k++) begin
                add_slot(lvl, 8 + int'($urandom_range(24)), $urandom);
                lvl = 1 - lvl;
            end
            lo = 2 + int'($urandom_range(3));
            hi = 2 + int'($urandom_range(3));
            run($sformatf("random%0d", t), lo, hi, 1 << 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
